// File: rtl/vram_fetch.sv
// Read engine for video RAM port B. It streams COUNT bytes starting at BASE into a valid/ready byte stream.
// Reads are issued only against credit: FIFO occupancy plus reads in flight. This keeps RAM latency from overflowing the output FIFO.
module vram_fetch #(
   parameter int AW    = 15,
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int LAT   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base_addr,
   input  logic [7:0]    count,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] ram_ad,
   output logic          ram_ce,
   output logic          ram_oce,
   input  logic [DW-1:0] ram_dout,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [1:0]    dbg_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    base_q, base_d;
   logic [7:0]       count_q, count_d;
   logic [7:0]       issued_q, issued_d;
   logic [LAT-1:0]   pipe_q, pipe_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    fcnt_q, fcnt_d;
   logic             done_q, done_d;
   logic [DW-1:0]    mem_q [DEPTH];
   logic [CW-1:0]    inflight;
   logic             fifo_wr, fifo_rd, credit_ok;

   // Stream handshake: a byte moves when m_valid & m_ready are both high at posedge.
   // m_valid never depends on m_ready, and m_data holds steady while m_valid is high and the byte has not been taken.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) inflight = inflight + CW'(pipe_q[i]);
   end

   assign credit_ok = (fcnt_q + inflight) < CW'(DEPTH);
   assign ram_ce    = (state_q == S_RUN) && credit_ok && !abort;
   assign ram_ad    = base_q + {{(AW-8){1'b0}}, issued_q};
   assign ram_oce   = 1'b1;
   assign fifo_wr   = pipe_q[LAT-1];
   assign m_valid   = (fcnt_q != '0);
   assign m_data    = mem_q[rd_ptr_q];
   assign fifo_rd   = m_valid && m_ready;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      count_d  = count_q;
      issued_d = ram_ce ? issued_q + 8'd1 : issued_q;
      pipe_d   = (pipe_q << 1) | LAT'(ram_ce);
      wr_ptr_d = fifo_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = fifo_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
      fcnt_d   = fcnt_q + CW'(fifo_wr) - CW'(fifo_rd);
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (count != 8'd0) begin
                  state_d  = S_RUN;
                  base_d   = base_addr;
                  count_d  = count;
                  issued_d = 8'd0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (ram_ce && (issued_q == count_q - 8'd1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave as the last byte is taken, so done lands one cycle after that transfer.
            if ((fcnt_d == '0) && (pipe_d == '0)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d  = S_IDLE;
         pipe_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fcnt_d   = '0;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         count_q  <= '0;
         issued_q <= '0;
         pipe_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         count_q  <= count_d;
         issued_q <= issued_d;
         pipe_q   <= pipe_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fcnt_q   <= fcnt_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) mem_q[wr_ptr_q] <= ram_dout;
   end

endmodule

// File: tb/tb_vram_fetch.sv
// Directed testbench for vram_fetch against a 2-cycle pipelined RAM model.
// Each test task logs addresses, transfers and done pulses, then compares them with hand-derived expectations.
module tb_vram_fetch;
   localparam int AW = 15;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [7:0]    count = '0;
   logic          busy, done, ram_ce, ram_oce, m_valid;
   logic          m_ready = 1'b0;
   logic [AW-1:0] ram_ad;
   logic [DW-1:0] ram_dout = '0;
   logic [DW-1:0] m_data;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   vram_fetch dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .base_addr(base_addr), .count(count), .busy(busy), .done(done),
      .ram_ad(ram_ad), .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_dout(ram_dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .dbg_state(dbg_state)
   );

   function automatic logic [7:0] ram_data(input logic [AW-1:0] a);
      return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
   endfunction

   // RAM model: address registered on ce, output register one cycle later
   logic [DW-1:0] s1 = '0;
   always @(posedge clk) begin
      if (ram_ce) s1 <= ram_data(ram_ad);
      if (ram_oce) ram_dout <= s1;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int busy_cnt = 0;
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] ad_q[$];
   int ce_cyc[$];
   int xfer_cyc[$];
   int done_cyc[$];

   task automatic clear_logs();
      got_q.delete(); exp_q.delete(); ad_q.delete();
      ce_cyc.delete(); xfer_cyc.delete(); done_cyc.delete();
      busy_cnt = 0;
   endtask

   // One clock cycle: observe settled outputs, then advance to the next negedge
   task automatic cyc();
      #1;
      if (m_valid && m_ready) begin got_q.push_back(m_data); xfer_cyc.push_back(cyc_n); end
      if (ram_ce) begin ad_q.push_back(ram_ad); ce_cyc.push_back(cyc_n); end
      if (done) done_cyc.push_back(cyc_n);
      if (busy) busy_cnt++;
      cyc_n++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [7:0] c);
      start = 1'b1; base_addr = b; count = c;
      cyc();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b exp 0", done); end
      n_cmp++; if (ram_ce !== 1'b0) begin n_bad++; $display("FAIL rst_ce got %b exp 0", ram_ce); end
      n_cmp++; if (ram_ad !== 15'h0) begin n_bad++; $display("FAIL rst_ad got %h exp 0", ram_ad); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", m_valid); end
      n_cmp++; if (ram_oce !== 1'b1) begin n_bad++; $display("FAIL rst_oce got %b exp 1", ram_oce); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      int s;
      clear_logs();
      m_ready = 1'b1;
      s = cyc_n;
      do_start(15'h0000, 8'd4);
      repeat (12) cyc();
      for (int i = 0; i < 4; i++) exp_q.push_back(ram_data(AW'(i)));
      n_cmp++; if (ad_q.size() != 4) begin n_bad++; $display("FAIL basic_nce got %0d exp 4", ad_q.size()); end
      for (int i = 0; i < 4 && i < ad_q.size(); i++) begin
         n_cmp++; if (ad_q[i] !== AW'(i)) begin n_bad++; $display("FAIL basic_ad[%0d] got %h exp %h", i, ad_q[i], i); end
         n_cmp++; if (ce_cyc[i] != s + 1 + i) begin n_bad++; $display("FAIL basic_ce_cyc[%0d] got %0d exp %0d", i, ce_cyc[i], s + 1 + i); end
      end
      n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL basic_len got %0d exp 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
         n_cmp++; if (xfer_cyc[i] != s + 4 + i) begin n_bad++; $display("FAIL basic_xfer_cyc[%0d] got %0d exp %0d", i, xfer_cyc[i], s + 4 + i); end
      end
      n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL basic_ndone got %0d exp 1", done_cyc.size()); end
      else begin
         n_cmp++; if (done_cyc[0] != s + 8) begin n_bad++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc[0], s + 8); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_ad [4];
      exp_ad = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      clear_logs();
      m_ready = 1'b1;
      do_start(15'h7FFE, 8'd4);
      repeat (12) cyc();
      n_cmp++; if (ad_q.size() != 4) begin n_bad++; $display("FAIL wrap_nce got %0d exp 4", ad_q.size()); end
      n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL wrap_len got %0d exp 4", got_q.size()); end
      for (int i = 0; i < 4 && i < ad_q.size() && i < got_q.size(); i++) begin
         n_cmp++; if (ad_q[i] !== exp_ad[i]) begin n_bad++; $display("FAIL wrap_ad[%0d] got %h exp %h", i, ad_q[i], exp_ad[i]); end
         n_cmp++; if (got_q[i] !== ram_data(exp_ad[i])) begin n_bad++; $display("FAIL wrap_data[%0d] got %h exp %h", i, got_q[i], ram_data(exp_ad[i])); end
      end
      n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL wrap_ndone got %0d exp 1", done_cyc.size()); end
   endtask

   task automatic test_backpressure();
      clear_logs();
      m_ready = 1'b0;
      do_start(15'h0040, 8'd16);
      repeat (10) cyc();
      n_cmp++; if (ad_q.size() != 4) begin n_bad++; $display("FAIL bp_stall_nce got %0d exp 4", ad_q.size()); end
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %b exp 1", m_valid); end
      m_ready = 1'b1;
      repeat (30) cyc();
      for (int i = 0; i < 16; i++) exp_q.push_back(ram_data(AW'(16'h0040 + i)));
      n_cmp++; if (got_q.size() != 16) begin n_bad++; $display("FAIL bp_len got %0d exp 16", got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (ad_q.size() != 16) begin n_bad++; $display("FAIL bp_nce got %0d exp 16", ad_q.size()); end
      n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL bp_ndone got %0d exp 1", done_cyc.size()); end
   endtask

   task automatic test_toggle();
      clear_logs();
      m_ready = 1'b1;
      do_start(15'h1234, 8'd8);
      for (int i = 0; i < 40; i++) begin
         m_ready = i[0];
         cyc();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(ram_data(AW'(16'h1234 + i)));
      n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL tog_len got %0d exp 8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL tog_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL tog_ndone got %0d exp 1", done_cyc.size()); end
   endtask

   task automatic test_abort();
      clear_logs();
      m_ready = 1'b0;
      do_start(15'h0200, 8'd16);
      repeat (3) cyc();
      n_cmp++; if (ad_q.size() != 3) begin n_bad++; $display("FAIL ab_nce got %0d exp 3", ad_q.size()); end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_busy got %b exp 0", busy); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ab_valid got %b exp 0", m_valid); end
      n_cmp++; if (ram_ce !== 1'b0) begin n_bad++; $display("FAIL ab_ce got %b exp 0", ram_ce); end
      m_ready = 1'b1;
      repeat (6) cyc();
      n_cmp++; if (done_cyc.size() != 0) begin n_bad++; $display("FAIL ab_done got %0d exp 0", done_cyc.size()); end
      n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL ab_stale got %0d exp 0", got_q.size()); end
      clear_logs();
      do_start(15'h0100, 8'd2);
      repeat (10) cyc();
      exp_q.push_back(ram_data(15'h0100));
      exp_q.push_back(ram_data(15'h0101));
      n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL ab_new_len got %0d exp 2", got_q.size()); end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ab_new_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL ab_new_ndone got %0d exp 1", done_cyc.size()); end
   endtask

   task automatic test_zero_and_reset();
      int s;
      clear_logs();
      m_ready = 1'b1;
      s = cyc_n;
      do_start(15'h0300, 8'd0);
      repeat (4) cyc();
      n_cmp++; if (ad_q.size() != 0) begin n_bad++; $display("FAIL zero_nce got %0d exp 0", ad_q.size()); end
      n_cmp++; if (busy_cnt != 0) begin n_bad++; $display("FAIL zero_busy got %0d exp 0", busy_cnt); end
      n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL zero_ndone got %0d exp 1", done_cyc.size()); end
      else begin
         n_cmp++; if (done_cyc[0] != s + 1) begin n_bad++; $display("FAIL zero_done_cyc got %0d exp %0d", done_cyc[0], s + 1); end
      end
      clear_logs();
      do_start(15'h0500, 8'd20);
      repeat (5) cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %b exp 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_done got %b exp 0", done); end
      n_cmp++; if (ram_ce !== 1'b0) begin n_bad++; $display("FAIL mrst_ce got %b exp 0", ram_ce); end
      n_cmp++; if (ram_ad !== 15'h0) begin n_bad++; $display("FAIL mrst_ad got %h exp 0", ram_ad); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b exp 0", m_valid); end
      repeat (5) cyc();
      n_cmp++; if (done_cyc.size() != 0) begin n_bad++; $display("FAIL mrst_ndone got %0d exp 0", done_cyc.size()); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_toggle();
      test_abort();
      test_zero_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
